// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and defaults for the timer scheduler.
package timer_sched_pkg;
  localparam int DEF_CNT_W = 10;
  typedef enum logic {IDLE, RUN} sched_state_t;
  typedef logic [DEF_CNT_W-1:0] tmr_cnt_t;
endpackage

// File: rtl/timer_core.sv
// timer_core: loadable down-counter that holds at zero and flags terminal count.
module timer_core
  import timer_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] data,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? data : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc = cnt_q == '0;
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin sharing of one interval timer among NUM_REQ requesters.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = DEF_CNT_W,
  localparam int OW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  input  logic [NUM_REQ-1:0]       abort,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [OW-1:0]            owner
);
  sched_state_t state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, pick;
  logic tc, tc_run, abort_own, expire, grant, load;
  logic [CNT_W-1:0] load_val;
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [OW-1:0] p);
    int j;
    rr_pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(p) + k) % NUM_REQ;
      if (r[j]) rr_pick = OW'(j);
    end
  endfunction
  timer_core #(.CNT_W(CNT_W)) u_core (
    .clk(clk), .reset(reset), .load(load), .data(load_val), .tc(tc)
  );
  always_comb begin
    pick      = rr_pick(req, rr_q);
    tc_run    = state_q == RUN && tc;
    abort_own = state_q == RUN && abort[owner_q];
    expire    = !reset && tc_run && !abort_own;
    grant     = !reset && |req && (state_q == IDLE || expire);
    load      = grant || abort_own;
    load_val  = grant ? req_count[pick*CNT_W +: CNT_W] : '0;
    gnt       = grant ? NUM_REQ'(1) << pick : '0;
    done      = expire ? NUM_REQ'(1) << owner_q : '0;
    owner_d   = grant ? pick : owner_q;
    rr_d      = grant ? OW'((int'(pick) + 1) % NUM_REQ) : rr_q;
    state_d   = abort_own ? IDLE : grant ? RUN : tc_run ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end
  assign busy  = state_q == RUN;
  assign owner = owner_q;
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed and randomized checks of timer_scheduler against an interval-level model.
module tb_timer_scheduler;
  logic clk = 0, reset = 1;
  logic [3:0] req = 0, abort = 0, gnt, done;
  logic [39:0] rc = 0;
  logic busy;
  logic [1:0] owner;
  int errs = 0, checks = 0;

  timer_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .req_count(rc), .abort(abort),
    .gnt(gnt), .done(done), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; req = 0; abort = 0;
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req = 4'b1111; abort = 4'b1111;
    next_cycle();
    @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errs++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0) begin errs++; $display("FAIL rst_done: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errs++; $display("FAIL rst_owner: got %0d want 0", owner); end
    reset = 0; abort = 0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errs++; $display("FAIL rst_rr0: got %b want 0001", gnt); end
    req = 0;
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010; rc[10 +: 10] = 3;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errs++; $display("FAIL single_gnt: got %b want 0010", gnt); end
    next_cycle();
    req = 0; rc = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (busy !== (c <= 4)) begin errs++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, c <= 4); end
      checks++; if (done !== (c == 4 ? 4'b0010 : 4'b0)) begin errs++; $display("FAIL single_done c%0d: got %b", c, done); end
      if (c <= 4) begin
        checks++; if (owner !== 2'd1) begin errs++; $display("FAIL single_owner c%0d: got %0d want 1", c, owner); end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg, ed;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) rc[i*10 +: 10] = 2;
    for (int c = 0; c <= 12; c++) begin
      eg = (c % 3 == 0) ? 4'b1 << ((c / 3) % 4) : 4'b0;
      ed = (c > 0 && c % 3 == 0) ? 4'b1 << (((c / 3) - 1) % 4) : 4'b0;
      @(negedge clk);
      checks++; if (gnt !== eg) begin errs++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, eg); end
      checks++; if (done !== ed) begin errs++; $display("FAIL rr_done c%0d: got %b want %b", c, done, ed); end
      checks++; if (busy !== (c > 0)) begin errs++; $display("FAIL rr_busy c%0d: got %b want %b", c, busy, c > 0); end
      next_cycle();
    end
    req = 0;
  endtask

  task automatic test_bounds();
    int ns[2] = '{0, 1023};
    int first, pulses;
    foreach (ns[k]) begin
      do_reset();
      req = 4'b1000; rc[30 +: 10] = 10'(ns[k]);
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) begin errs++; $display("FAIL bound_gnt n%0d: got %b want 1000", ns[k], gnt); end
      next_cycle();
      req = 0; rc = 0;
      first = -1; pulses = 0;
      for (int c = 1; c <= ns[k] + 4; c++) begin
        @(negedge clk);
        if (done !== 4'b0) begin
          pulses++;
          if (first < 0) first = c;
        end
        next_cycle();
      end
      checks++; if (first != ns[k] + 1) begin errs++; $display("FAIL bound_latency n%0d: got %0d want %0d", ns[k], first, ns[k] + 1); end
      checks++; if (pulses != 1) begin errs++; $display("FAIL bound_pulses n%0d: got %0d want 1", ns[k], pulses); end
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    do_reset();
    req = 4'b0100; rc[20 +: 10] = 10;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errs++; $display("FAIL abort_gnt: got %b want 0100", gnt); end
    next_cycle();
    req = 0;
    abort = 4'b0001;
    next_cycle();
    abort = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || owner !== 2'd2) begin errs++; $display("FAIL abort_nonowner: got busy=%b owner=%0d want 1/2", busy, owner); end
    next_cycle();
    abort = 4'b0100; req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errs++; $display("FAIL abort_nogrant: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0) begin errs++; $display("FAIL abort_nodone: got %b want 0000", done); end
    next_cycle();
    abort = 0; req = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done !== 4'b0) pulses++;
      next_cycle();
    end
    checks++; if (pulses != 0) begin errs++; $display("FAIL abort_late_done: got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; rc[10 +: 10] = 8;
    next_cycle();
    req = 0;
    repeat (3) next_cycle();
    reset = 1; req = 4'b0110;
    @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errs++; $display("FAIL midrst_gnt_in_reset: got %b want 0000", gnt); end
    next_cycle();
    reset = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 4'b0) begin errs++; $display("FAIL midrst_done: got %b want 0000", done); end
    checks++; if (gnt !== 4'b0010) begin errs++; $display("FAIL midrst_rr: got %b want 0010", gnt); end
    req = 0;
    next_cycle();
  endtask

  task automatic test_random();
    bit m_busy = 0;
    int m_owner = 0, m_rem = 0, m_rr = 0, win;
    int n_grant = 0, n_abort = 0, n_done = 0, max_wait = 0;
    int wait_c[4] = '{0, 0, 0, 0};
    int cnt[4];
    bit expired, ab;
    logic [3:0] eg, ed;
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1;
        cnt[i] = $urandom_range(0, 32);
        rc[i*10 +: 10] = 10'(cnt[i]);
      end
      abort = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
      expired = m_busy && m_rem == 0;
      ab = m_busy && abort[m_owner];
      win = -1;
      if (!m_busy || (expired && !ab))
        for (int k = 3; k >= 0; k--) if (req[(m_rr + k) % 4]) win = (m_rr + k) % 4;
      eg = win >= 0 ? 4'b1 << win : 4'b0;
      ed = (expired && !ab) ? 4'b1 << m_owner : 4'b0;
      @(negedge clk);
      checks++; if (gnt !== eg) begin errs++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, eg); end
      checks++; if ($countones(gnt) > 1) begin errs++; $display("FAIL rand_onehot c%0d: got %b", c, gnt); end
      checks++; if (done !== ed) begin errs++; $display("FAIL rand_done c%0d: got %b want %b", c, done, ed); end
      checks++; if (busy !== m_busy) begin errs++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_busy); end
      if (m_busy) begin
        checks++; if (owner !== 2'(m_owner)) begin errs++; $display("FAIL rand_owner c%0d: got %0d want %0d", c, owner, m_owner); end
      end
      if (done !== 4'b0) n_done++;
      if (ab) begin m_busy = 0; n_abort++; end
      else if (win >= 0) begin m_busy = 1; m_owner = win; m_rem = cnt[win]; m_rr = (win + 1) % 4; n_grant++; end
      else if (expired) m_busy = 0;
      else if (m_busy) m_rem--;
      for (int i = 0; i < 4; i++) begin
        wait_c[i] = (req[i] && i != win) ? wait_c[i] + 1 : 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      next_cycle();
      if (win >= 0) req[win] = 0;
    end
    checks++; if (n_grant != n_abort + n_done + (m_busy ? 1 : 0)) begin errs++; $display("FAIL rand_done_count: got %0d want %0d", n_done, n_grant - n_abort - (m_busy ? 1 : 0)); end
    checks++; if (max_wait > 160) begin errs++; $display("FAIL rand_starvation: got %0d want <=160", max_wait); end
    req = 0; abort = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bounds();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
